// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard front end: synchronizes the PS/2 lines, deframes scan codes, tracks
// make/break/extended prefixes and Shift/Caps state, and drives ASCII of the held key.
// Optional: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii_code,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       shift_on,
    output logic       caps_on,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_NORM, S_BRK, S_EXT, S_EXT_BRK} state_t;

    logic [2:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;   // data is taken from stage 2, a third stage would never be read
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_frame;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_scan;
    logic          r_cv;
    logic          r_ferr;
    state_t        r_state, w_next;
    logic          w_make, w_brk;
    logic          r_shl, r_shr, r_caps, r_caps_held;
    logic [7:0]    r_held, r_ascii;
    logic          w_fall, w_din, w_par_ok, w_good;
    logic [8:0]    w_map;

    assign w_fall = ~r_clk_sync[1] & r_clk_sync[2];
    assign w_din  = r_dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = ^r_frame[9:1];
`else
    assign w_par_ok = 1'b1;
`endif
    // r_frame[0] is the start bit once ten bits have been shifted in
    assign w_good = ~r_frame[0] & w_din & w_par_ok;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync <= '0;
            r_dat_sync <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bit_cnt <= '0;
            r_frame   <= '0;
            r_to_cnt  <= '0;
            r_scan    <= '0;
            r_cv      <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_cv <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= '0;
                    if (w_good) begin
                        r_scan <= r_frame[8:1];
                        r_cv   <= 1'b1;
                    end else begin
                        r_ferr <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_frame   <= {w_din, r_frame[9:1]};
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == TW'(TIMEOUT_CYCLES)) begin
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= S_NORM;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_make = 1'b0;
        w_brk  = 1'b0;
        if (r_cv) begin
            case (r_state)
                S_NORM: begin
                    if (r_scan == 8'hF0)      w_next = S_BRK;
                    else if (r_scan == 8'hE0) w_next = S_EXT;
                    else                      w_make = 1'b1;
                end
                S_BRK: begin
                    w_brk  = 1'b1;
                    w_next = S_NORM;
                end
                S_EXT:     w_next = (r_scan == 8'hF0) ? S_EXT_BRK : S_NORM;
                S_EXT_BRK: w_next = S_NORM;
                default:   w_next = S_NORM;
            endcase
        end
    end

    // Returns {mapped, ascii}; letters become uppercase when 'upper' is set
    function automatic logic [8:0] f_map(input logic [7:0] c, input logic upper);
        logic [7:0] a;
        logic       hit;
        a   = 8'h00;
        hit = 1'b1;
        case (c)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
            default: hit = 1'b0;
        endcase
        if (upper && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
        return {hit, a};
    endfunction

    assign w_map = f_map(r_scan, (r_shl | r_shr) ^ r_caps);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_shl       <= 1'b0;
            r_shr       <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_held      <= '0;
            r_ascii     <= '0;
        end else if (w_make) begin
            case (r_scan)
                8'h12: r_shl <= 1'b1;
                8'h59: r_shr <= 1'b1;
                8'h58: begin
                    if (!r_caps_held) r_caps <= ~r_caps;
                    r_caps_held <= 1'b1;
                end
                default: if (w_map[8]) begin
                    r_held  <= r_scan;
                    r_ascii <= w_map[7:0];
                end
            endcase
        end else if (w_brk) begin
            case (r_scan)
                8'h12: r_shl <= 1'b0;
                8'h59: r_shr <= 1'b0;
                8'h58: r_caps_held <= 1'b0;
                default: if (r_scan == r_held && r_held != 8'h00) begin
                    r_ascii <= 8'h00;
                    r_held  <= 8'h00;
                end
            endcase
        end
    end

    assign ascii_code = r_ascii;
    assign scan_code  = r_scan;
    assign code_valid = r_cv;
    assign shift_on   = r_shl | r_shr;
    assign caps_on    = r_caps;
    assign frame_err  = r_ferr;
endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Bench for ps2_keyboard_decoder: directed table, random stream vs. a keyboard model,
// and hand sequences for parity, framing, timeout and mid-frame reset.
module tb_ps2_keyboard_decoder;
    localparam int TO   = 400;
    localparam int HALF = 8;

    logic       clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] ascii_code, scan_code;
    logic       code_valid, shift_on, caps_on, frame_err;

    int n_tests = 0, n_fail = 0, n_pulse = 0;

    ps2_keyboard_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ascii_code(ascii_code), .scan_code(scan_code), .code_valid(code_valid),
        .shift_on(shift_on), .caps_on(caps_on), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (code_valid === 1'b1) n_pulse++;

    typedef struct {
        logic [7:0] code;
        logic [7:0] ascii;
        bit         shift;
        bit         caps;
    } vec_t;
    vec_t tbl[$];

    // keyboard model state
    bit         m_e0, m_f0, m_shl, m_shr, m_caps, m_caps_held;
    logic [7:0] m_held, m_ascii;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int first, input int last);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ~(^b) ^ bad_par;
        f[10]  = ~bad_stop;
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(b, bad_par, bad_stop, 0, 10);
        tick(2 * HALF);
    endtask

    function automatic int ref_map(input logic [7:0] b, input bit up);
        logic [7:0] L[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] D[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 26; i++) if (L[i] == b) return (up ? 65 : 97) + i;
        for (int i = 0; i < 10; i++) if (D[i] == b) return 48 + i;
        if (b == 8'h29) return 32;
        if (b == 8'h5A) return 13;
        if (b == 8'h66) return 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_e0 = 0; m_f0 = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_caps_held = 0;
        m_held = 0; m_ascii = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit brk, ext;
        int a;
        if (!m_f0 && b == 8'hF0) begin m_f0 = 1; return; end
        if (!m_f0 && !m_e0 && b == 8'hE0) begin m_e0 = 1; return; end
        brk = m_f0; ext = m_e0; m_f0 = 0; m_e0 = 0;
        if (ext) return;
        if (!brk) begin
            if (b == 8'h12) m_shl = 1;
            else if (b == 8'h59) m_shr = 1;
            else if (b == 8'h58) begin
                if (!m_caps_held) m_caps = !m_caps;
                m_caps_held = 1;
            end else begin
                a = ref_map(b, (m_shl || m_shr) != m_caps);
                if (a >= 0) begin m_held = b; m_ascii = 8'(a); end
            end
        end else begin
            if (b == 8'h12) m_shl = 0;
            else if (b == 8'h59) m_shr = 0;
            else if (b == 8'h58) m_caps_held = 0;
            else if (b == m_held && m_held != 0) begin m_ascii = 0; m_held = 0; end
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        tick(3);
        clrn = 1'b1;
        tick(2);
    endtask

    task automatic add(input logic [7:0] c, input logic [7:0] a, input bit s, input bit k);
        vec_t v;
        v.code = c; v.ascii = a; v.shift = s; v.caps = k;
        tbl.push_back(v);
    endtask

    initial begin
        int p0;
        logic [7:0] b;

        // make/break, shift, caps, extended, replacement, digits and specials
        add(8'h1C, 8'h61, 0, 0); add(8'hF0, 8'h61, 0, 0); add(8'h1C, 8'h00, 0, 0);
        add(8'h12, 8'h00, 1, 0); add(8'h1C, 8'h41, 1, 0); add(8'hF0, 8'h41, 1, 0);
        add(8'h1C, 8'h00, 1, 0); add(8'hF0, 8'h00, 1, 0); add(8'h12, 8'h00, 0, 0);
        add(8'h58, 8'h00, 0, 1); add(8'hF0, 8'h00, 0, 1); add(8'h58, 8'h00, 0, 1);
        add(8'h58, 8'h00, 0, 0); add(8'h58, 8'h00, 0, 0); add(8'hF0, 8'h00, 0, 0);
        add(8'h58, 8'h00, 0, 0); add(8'h1C, 8'h61, 0, 0); add(8'hF0, 8'h61, 0, 0);
        add(8'h1C, 8'h00, 0, 0);
        add(8'h58, 8'h00, 0, 1); add(8'hF0, 8'h00, 0, 1); add(8'h58, 8'h00, 0, 1);
        add(8'h1C, 8'h41, 0, 1); add(8'hF0, 8'h41, 0, 1); add(8'h1C, 8'h00, 0, 1);
        add(8'hE0, 8'h00, 0, 1); add(8'h75, 8'h00, 0, 1); add(8'hE0, 8'h00, 0, 1);
        add(8'hF0, 8'h00, 0, 1); add(8'h75, 8'h00, 0, 1); add(8'hE0, 8'h00, 0, 1);
        add(8'h12, 8'h00, 0, 1); add(8'h1C, 8'h41, 0, 1); add(8'h32, 8'h42, 0, 1);
        add(8'hF0, 8'h42, 0, 1); add(8'h1C, 8'h42, 0, 1); add(8'hF0, 8'h42, 0, 1);
        add(8'h32, 8'h00, 0, 1); add(8'h45, 8'h30, 0, 1); add(8'hF0, 8'h30, 0, 1);
        add(8'h45, 8'h00, 0, 1); add(8'h12, 8'h00, 1, 1); add(8'h16, 8'h31, 1, 1);
        add(8'hF0, 8'h31, 1, 1); add(8'h16, 8'h00, 1, 1); add(8'hF0, 8'h00, 1, 1);
        add(8'h12, 8'h00, 0, 1); add(8'h29, 8'h20, 0, 1); add(8'h5A, 8'h0D, 0, 1);
        add(8'h66, 8'h08, 0, 1);

        tick(3);
        chk("rst_ascii", ascii_code, 8'h00);
        chk("rst_scan", scan_code, 8'h00);
        chk("rst_flags", {code_valid, shift_on, caps_on, frame_err}, 4'b0000);
        clrn = 1'b1;
        tick(2);

        foreach (tbl[i]) begin
            p0 = n_pulse;
            send_frame(tbl[i].code, 0, 0);
            chk($sformatf("tbl%0d_pulse", i), n_pulse - p0, 1);
            chk($sformatf("tbl%0d_scan", i), scan_code, tbl[i].code);
            chk($sformatf("tbl%0d_ascii", i), ascii_code, tbl[i].ascii);
            chk($sformatf("tbl%0d_shift", i), shift_on, tbl[i].shift);
            chk($sformatf("tbl%0d_caps", i), caps_on, tbl[i].caps);
        end
        chk("tbl_ferr", frame_err, 0);

        // random stream vs. model
        do_reset();
        model_reset();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = 8'h1C + 8'($urandom_range(0, 1)) * 8'h16;
                4: b = 8'h45;
                5: b = $urandom_range(0, 1) ? 8'h12 : 8'h59;
                6: b = 8'h58;
                7: b = 8'hF0;
                8: b = 8'hE0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if (i % 7 == 3) b = 8'h1A;
            p0 = n_pulse;
            send_frame(b, 0, 0);
            model_byte(b);
            chk($sformatf("rnd%0d_pulse", i), n_pulse - p0, 1);
            chk($sformatf("rnd%0d_scan", i), scan_code, b);
            chk($sformatf("rnd%0d_ascii", i), ascii_code, m_ascii);
            chk($sformatf("rnd%0d_shift", i), shift_on, m_shl | m_shr);
            chk($sformatf("rnd%0d_caps", i), caps_on, m_caps);
        end
        chk("rnd_ferr", frame_err, 0);

        // wrong parity, then bad stop bit
        do_reset();
        p0 = n_pulse;
        send_frame(8'h1C, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
        chk("par_pulse", n_pulse - p0, 0);
        chk("par_ferr", frame_err, 1);
        chk("par_ascii", ascii_code, 8'h00);
`else
        chk("par_pulse", n_pulse - p0, 1);
        chk("par_ferr", frame_err, 0);
        chk("par_ascii", ascii_code, 8'h61);
`endif
        p0 = n_pulse;
        send_frame(8'h32, 0, 1);
        chk("stop_pulse", n_pulse - p0, 0);
        chk("stop_ferr", frame_err, 1);
        send_frame(8'h29, 0, 0);
        chk("ferr_sticky", frame_err, 1);

        // partial frame then timeout
        do_reset();
        send_bits(8'h1C, 0, 0, 0, 4);
        tick(TO + 2);
        p0 = n_pulse;
        send_frame(8'h29, 0, 0);
        chk("to_pulse", n_pulse - p0, 1);
        chk("to_ascii", ascii_code, 8'h20);
        chk("to_ferr", frame_err, 0);

        // reset in the middle of a frame while a key and caps are held
        do_reset();
        send_frame(8'h58, 0, 0);
        send_frame(8'h1C, 0, 0);
        chk("mid_pre_ascii", ascii_code, 8'h41);
        send_bits(8'h32, 0, 0, 0, 4);
        clrn = 1'b0;
        #1;
        chk("mid_rst_ascii", ascii_code, 8'h00);
        chk("mid_rst_caps", caps_on, 0);
        chk("mid_rst_scan", scan_code, 8'h00);
        tick(2);
        clrn = 1'b1;
        send_bits(8'h32, 0, 0, 5, 10);
        tick(TO + 2);
        p0 = n_pulse;
        send_frame(8'h29, 0, 0);
        chk("mid_pulse", n_pulse - p0, 1);
        chk("mid_ascii", ascii_code, 8'h20);
        chk("mid_ferr", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
